// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for a 4-bit loadable up/down counter: walks q from start to end,
// optionally repeating or ping-ponging, then holds the counter on the final value.
module updown_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic [REP_W-1:0] cmd_repeat,
    input  logic             cmd_bounce,
    input  logic             cmd_abort,
    output logic             cnt_load,
    output logic             cnt_mode,
    output logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] sweeps_left
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] cur_start, cur_start_nx;
    logic [WIDTH-1:0] cur_end, cur_end_nx;
    logic [WIDTH-1:0] hold_r, hold_nx;
    logic             dir, dir_nx;
    logic             bounce_r, bounce_nx;
    logic [REP_W-1:0] sweeps_nx;
    logic             accept;
    logic             hit;

    assign cmd_ready = (state == IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign hit       = (cnt_q == cur_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_start   <= '0;
            cur_end     <= '0;
            hold_r      <= '0;
            dir         <= 1'b1;
            bounce_r    <= 1'b0;
            sweeps_left <= '0;
        end else begin
            state       <= state_nx;
            cur_start   <= cur_start_nx;
            cur_end     <= cur_end_nx;
            hold_r      <= hold_nx;
            dir         <= dir_nx;
            bounce_r    <= bounce_nx;
            sweeps_left <= sweeps_nx;
        end
    end

    // The counter never pauses, so every state except a free-running RUN cycle keeps it loaded.
    always_comb begin
        state_nx     = state;
        cur_start_nx = cur_start;
        cur_end_nx   = cur_end;
        hold_nx      = hold_r;
        dir_nx       = dir;
        bounce_nx    = bounce_r;
        sweeps_nx    = sweeps_left;
        cnt_load     = 1'b1;
        cnt_mode     = 1'b1;
        cnt_in       = hold_r;
        busy         = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    cur_start_nx = cmd_start;
                    cur_end_nx   = cmd_end;
                    dir_nx       = (cmd_end >= cmd_start);
                    sweeps_nx    = (cmd_repeat == '0) ? REP_W'(1) : cmd_repeat;
                    bounce_nx    = cmd_bounce;
                    state_nx     = LOAD;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                cnt_mode = dir;
                if (cmd_abort) begin
                    cnt_in    = cnt_q;
                    hold_nx   = cnt_q;
                    sweeps_nx = '0;
                    state_nx  = DONE;
                end else begin
                    cnt_in   = cur_start;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                cnt_mode = dir;
                cnt_load = 1'b0;
                if (cmd_abort) begin
                    cnt_load  = 1'b1;
                    cnt_in    = cnt_q;
                    hold_nx   = cnt_q;
                    sweeps_nx = '0;
                    state_nx  = DONE;
                end else if (hit) begin
                    cnt_load = 1'b1;
                    if (sweeps_left > REP_W'(1)) begin
                        sweeps_nx = sweeps_left - REP_W'(1);
                        // Bounce reloads the end value so the turnaround shows twice on q.
                        if (bounce_r) begin
                            cnt_in       = cur_end;
                            cur_start_nx = cur_end;
                            cur_end_nx   = cur_start;
                            dir_nx       = ~dir;
                        end else begin
                            cnt_in = cur_start;
                        end
                    end else begin
                        cnt_in    = cur_end;
                        hold_nx   = cur_end;
                        sweeps_nx = '0;
                        state_nx  = DONE;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
